// File: rtl/fp_int_pkg.sv
// Shared definitions for the bit-serial FP x INT multiplier interface:
// default widths, precision limits, FSM states and the precision clamp.
package fp_int_pkg;

    localparam int ACT_WIDTH  = 16;
    localparam int W_MAX      = 8;
    localparam int PREC_MIN   = 2;
    localparam int PREC_W     = 4;
    localparam int PREC_RESET = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STREAM
    } state_t;

    // Limit a requested precision to the range the multiplier supports.
    function automatic logic [PREC_W-1:0] clamp_precision(
        input logic [PREC_W-1:0] req,
        input int                w_max
    );
        logic [PREC_W-1:0] res;
        if (int'(req) < PREC_MIN) begin
            res = PREC_W'(PREC_MIN);
        end else if (int'(req) > w_max) begin
            res = PREC_W'(w_max);
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/weight_bit_serializer.sv
// Turns parallel (activation, weight) pairs into the MSB-first serial weight
// stream of the bit-serial multiplier, with act held for the whole word.
// A precision load spends two cycles away from accepting words: the set
// pulse cycle (SETUP) and one guard cycle afterwards (guard_q).
module weight_bit_serializer #(
    parameter int ACT_WIDTH = fp_int_pkg::ACT_WIDTH,
    parameter int W_MAX     = fp_int_pkg::W_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_set,
    input  logic [3:0]           cfg_precision,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [W_MAX-1:0]     in_weight,
    output logic                 set,
    output logic [3:0]           precision,
    output logic                 valid,
    output logic                 w,
    output logic [ACT_WIDTH-1:0] act,
    output logic                 busy
);
    import fp_int_pkg::*;

    state_t           state_q, state_d;
    logic [W_MAX-1:0] shreg_q;
    logic [3:0]       cnt_q;
    logic             guard_q;
    logic             accept;
    logic             cfg_take;
    logic [W_MAX-1:0] aligned;

    assign cfg_ready = (state_q == IDLE) && !guard_q;
    assign in_ready  = (cfg_ready && !cfg_set) || (state_q == STREAM && cnt_q == 4'd0);
    assign accept    = in_valid && in_ready;
    assign cfg_take  = cfg_ready && cfg_set;
    assign busy      = (state_q != IDLE);

    // Left-align the active bits so the word MSB sits at the top of the
    // shift register; bits at or above precision fall off the top.
    assign aligned = in_weight << (4'(W_MAX) - precision);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic; config requests win over input words in IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_take) begin
                    state_d = SETUP;
                end else if (accept) begin
                    state_d = STREAM;
                end
            end
            SETUP:   state_d = IDLE;
            STREAM: begin
                if (cnt_q == 4'd0 && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set       <= 1'b0;
            precision <= 4'(PREC_RESET);
            valid     <= 1'b0;
            w         <= 1'b0;
            act       <= '0;
            shreg_q   <= '0;
            cnt_q     <= 4'd0;
            guard_q   <= 1'b0;
        end else begin
            set     <= 1'b0;
            guard_q <= (state_q == SETUP);

            if (cfg_take) begin
                set       <= 1'b1;
                precision <= clamp_precision(cfg_precision, W_MAX);
            end

            if (accept) begin
                valid   <= 1'b1;
                w       <= aligned[W_MAX-1];
                shreg_q <= aligned << 1;
                cnt_q   <= precision - 4'd1;
                act     <= in_act;
            end else if (state_q == STREAM && cnt_q != 4'd0) begin
                valid   <= 1'b1;
                w       <= shreg_q[W_MAX-1];
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - 4'd1;
            end else begin
                valid <= 1'b0;
                w     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Self-checking bench for weight_bit_serializer: a queue-based model of the
// serial stream checked every cycle, plus hand-computed literal expectations.
module tb_weight_bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_set;
    logic [3:0]  cfg_precision;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [7:0]  in_weight;
    logic        set;
    logic [3:0]  precision;
    logic        valid;
    logic        w;
    logic [15:0] act;
    logic        busy;

    weight_bit_serializer #(.ACT_WIDTH(16), .W_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_set(cfg_set), .cfg_precision(cfg_precision), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
        .set(set), .precision(precision), .valid(valid), .w(w), .act(act), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_prec;
    bit          m_set, m_valid, m_w;
    logic [15:0] m_act;
    int          m_block;      // cycles left in which no config/word may be taken
    bit          q_bits[$];    // bits of the current word still to be sent
    bit          acc_flag;     // a word was accepted at the latest edge

    function automatic int clampv(input int p);
        return (p < 2) ? 2 : ((p > 8) ? 8 : p);
    endfunction

    function automatic bit m_cfg_ready();
        return !m_valid && m_block == 0;
    endfunction

    function automatic bit m_ready();
        return (q_bits.size() == 0) && m_block == 0 && (m_valid || !cfg_set);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prec = 4; m_set = 0; m_valid = 0; m_w = 0; m_act = '0;
            m_block = 0; q_bits.delete(); acc_flag = 0;
        end else begin
            bit rdy, cfg_ok, acc;
            rdy    = m_ready();
            cfg_ok = m_cfg_ready() && cfg_set;
            acc    = in_valid && rdy;
            if (m_block > 0) m_block--;
            m_set = 0;
            if (cfg_ok) begin
                m_set   = 1;
                m_prec  = clampv(int'(cfg_precision));
                m_block = 2;
            end
            if (acc) begin
                q_bits.delete();
                for (int i = m_prec - 1; i >= 0; i--) q_bits.push_back(in_weight[i]);
                m_act = in_act;
            end
            if (q_bits.size() > 0) begin
                m_w = q_bits.pop_front();
                m_valid = 1;
            end else begin
                m_w = 0;
                m_valid = 0;
            end
            acc_flag = acc;
        end
    end

    // ---------------- per-cycle compare and stream recorder ----------------
    bit          wlog[$];
    logic [15:0] alog[$];
    int          set_cnt, last_set_prec, runs;
    bit          prev_valid;

    always @(negedge clk) begin
        if (rst) begin
            check("set", 32'(set), 32'(m_set));
            check("precision", 32'(precision), 32'(m_prec));
            check("valid", 32'(valid), 32'(m_valid));
            if (m_valid) check("w", 32'(w), 32'(m_w));
            check("act", 32'(act), 32'(m_act));
            check("busy", 32'(busy), 32'(m_valid || m_set));
            check("in_ready", 32'(in_ready), 32'(m_ready()));
            check("cfg_ready", 32'(cfg_ready), 32'(m_cfg_ready()));
            if (valid) begin
                wlog.push_back(w);
                alog.push_back(act);
                if (!prev_valid) runs++;
            end
            if (set) begin
                set_cnt++;
                last_set_prec = int'(precision);
            end
            prev_valid = valid;
        end else begin
            prev_valid = 0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete();
        alog.delete();
        set_cnt = 0;
        runs = 0;
    endtask

    task automatic do_cfg(input logic [3:0] p);
        cfg_set = 1'b1;
        cfg_precision = p;
        tick();
        cfg_set = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] wt);
        bit got = 0;
        in_valid  = 1'b1;
        in_act    = a;
        in_weight = wt;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = acc_flag;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (!m_valid && q_bits.size() == 0 && m_block == 0 && !m_set) done = 1;
            else tick();
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pack_w();
        logic [31:0] v = '0;
        foreach (wlog[i]) v = (v << 1) | 32'(wlog[i]);
        return v;
    endfunction

    function automatic int act_mismatches(input logic [15:0] exp);
        int bad = 0;
        foreach (alog[i]) if (alog[i] !== exp) bad++;
        return bad;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_set"}, 32'(set), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_w"}, 32'(w), 32'd0);
        check({tag, "_act"}, 32'(act), 32'd0);
        check({tag, "_precision"}, 32'(precision), 32'd4);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b0; cfg_set = 1'b0; cfg_precision = 4'd0;
        in_valid = 1'b0; in_act = '0; in_weight = '0;
        clear_logs();
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b1;
        tick();

        // 1: single word at precision 4
        clear_logs();
        do_cfg(4'd4);
        send(16'h1234, 8'h05);
        drain();
        check("t1_set_count", 32'(set_cnt), 32'd1);
        check("t1_set_prec", 32'(last_set_prec), 32'd4);
        check("t1_len", 32'(wlog.size()), 32'd4);
        check("t1_bits", pack_w(), 32'b0101);
        check("t1_act_bad", 32'(act_mismatches(16'h1234)), 32'd0);

        // 2: back-to-back words, upper weight bits are garbage
        clear_logs();
        send(16'h1234, 8'hF5);
        send(16'hF234, 8'h3A);
        drain();
        check("t2_len", 32'(wlog.size()), 32'd8);
        check("t2_runs", 32'(runs), 32'd1);
        check("t2_bits", pack_w(), 32'b01011010);
        if (alog.size() == 8) begin
            check("t2_act_bit4", 32'(alog[3]), 32'h1234);
            check("t2_act_bit5", 32'(alog[4]), 32'hF234);
        end else begin
            check("t2_act_len", 32'(alog.size()), 32'd8);
        end

        // 3a: clamp low
        do_cfg(4'd0);
        drain();
        check("t3_prec_low", 32'(precision), 32'd2);
        clear_logs();
        send(16'h0ABC, 8'hFE);
        drain();
        check("t3_len_low", 32'(wlog.size()), 32'd2);
        check("t3_bits_low", pack_w(), 32'b10);

        // 3b: clamp high
        do_cfg(4'd12);
        drain();
        check("t3_prec_high", 32'(precision), 32'd8);
        clear_logs();
        send(16'h5555, 8'hA5);
        drain();
        check("t3_len_high", 32'(wlog.size()), 32'd8);
        check("t3_bits_high", pack_w(), 32'hA5);

        // 4: config request while a word is in flight is ignored
        do_cfg(4'd4);
        drain();
        clear_logs();
        send(16'h2222, 8'h0C);
        cfg_set = 1'b1;
        cfg_precision = 4'd6;
        check("t4_cfg_ready_busy", 32'(cfg_ready), 32'd0);
        tick();
        cfg_set = 1'b0;
        drain();
        check("t4_prec_kept", 32'(precision), 32'd4);
        check("t4_no_set", 32'(set_cnt), 32'd0);
        check("t4_bits", pack_w(), 32'b1100);

        // 5: underflow gap then a fresh word
        clear_logs();
        send(16'h7777, 8'h09);
        drain();
        check("t5_valid_gap", 32'(valid), 32'd0);
        check("t5_busy_gap", 32'(busy), 32'd0);
        check("t5_act_held", 32'(act), 32'h7777);
        tick(); tick(); tick();
        send(16'h8888, 8'h06);
        drain();
        check("t5_len", 32'(wlog.size()), 32'd8);
        check("t5_runs", 32'(runs), 32'd2);
        check("t5_bits", pack_w(), 32'b10010110);

        // 6: asynchronous reset after bit 2 of a word
        clear_logs();
        send(16'h4444, 8'h0B);
        tick();
        #2 rst = 1'b0;
        #1 check_reset_values("midrst");
        tick(); tick();
        rst = 1'b1;
        tick();
        clear_logs();
        check("t6_prec", 32'(precision), 32'd4);
        send(16'h3333, 8'h0D);
        drain();
        check("t6_len", 32'(wlog.size()), 32'd4);
        check("t6_bits", pack_w(), 32'b1101);
        check("t6_act_bad", 32'(act_mismatches(16'h3333)), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_bit_serializer.md
# weight_bit_serializer

Transmit side of the bit-serial FP×INT multiplier interface. Accepts parallel (FP16 activation, INT weight) pairs over a ready/valid handshake and emits the `set`/`precision`/`valid`/`w`/`act` stream that `fp_int_mul_bit_serial` consumes. Weights go out MSB-first, one bit per cycle, with `act` held stable for the whole word. Sits between the weight buffer and the multiplier lane.

## Interface

**Parameters**
- `ACT_WIDTH`, 16, activation width (FP16).
- `W_MAX`, 8, maximum weight precision in bits; legal range 2..15.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_set` in 1: one-cycle request to load a new precision.
- `cfg_precision` in 4: requested precision.
- `cfg_ready` out 1: high only in IDLE; `cfg_set` is accepted only when `cfg_ready`=1.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: input word accepted when `in_valid && in_ready`.
- `in_act` in ACT_WIDTH: activation.
- `in_weight` in W_MAX: two's-complement weight. The lower `precision` bits are used.
- `set` out 1: one-cycle precision-load pulse to the multiplier.
- `precision` out 4: current precision, held between loads.
- `valid` out 1: `w` carries a weight bit this cycle.
- `w` out 1: serial weight bit.
- `act` out ACT_WIDTH: activation for the word in flight.
- `busy` out 1: state ≠ IDLE.

## Operation

- State machine with three states:
  - **IDLE**
    - `cfg_set` → SETUP: latch the clamped precision and pulse `set` on the next cycle.
    - Accepted input → STREAM.
  - **SETUP**: lasts exactly one cycle with `valid`=0, giving the multiplier a guard cycle after `set`. Then → IDLE.
  - **STREAM**
    - On word accept: load a shift register with `in_weight[precision-1:0]`, latch `in_act`, and set the bit counter to `precision-1`.
    - Each cycle: `w` = current MSB, then shift left and decrement the counter.
    - On the last bit (counter = 0):
      - If a new word is accepted the same cycle → reload, staying in STREAM.
      - Otherwise → IDLE.
- `in_ready` = (state==IDLE && !cfg_set) || (state==STREAM && counter==0).
  - `cfg_set` has priority over `in_valid` in IDLE.
- Precision clamp, applied at load:
  - `cfg_precision` < 2 → 2.
  - `cfg_precision` > W_MAX → W_MAX.
- `act` updates only at a word boundary and is held otherwise. `act` keeps its last value while idle.
- There is no downstream backpressure; the multiplier always consumes.
- Bits of `in_weight` at or above `precision` are ignored.
- Reset mid-stream aborts the word immediately: no partial-word recovery, and the next word starts clean.

## Timing

- **Reset values**: `set`=0, `valid`=0, `w`=0, `act`=0, `precision`=4, `busy`=0, `cfg_ready`=1, `in_ready`=1. State is IDLE.
- **Outputs**: all registered. `in_ready` and `cfg_ready` are combinational from state and counter.
- **Config**: `cfg_set` at edge N → `set`=1 during cycle N+1, with `precision` updated in the same cycle. Cycle N+2 is the SETUP guard. The earliest input accept is at edge N+3.
- **Streaming**:
  - Word accepted at edge N → `valid`=1 with `w`=bit[p-1] in cycle N+1, through bit[0] in cycle N+p.
  - First-bit latency is 1 cycle.
  - A back-to-back accept at edge N+p gives `valid` continuous with zero bubbles.
- **Underflow**: no word at the last bit → `valid`=0 from cycle N+p+1.
- **Throughput**: one word per `precision` cycles.

## Structure

- Shared package `fp_int_pkg`:
  - `W_MAX`, `ACT_WIDTH`, `PREC_MIN`=2.
  - State enum {IDLE, SETUP, STREAM}.
  - `clamp_precision()` function.
  - The multiplier uses the same package.
- No sub-module is needed. The shift register, down-counter and FSM live in one module.

## Test plan

1. **Single word.** Reset, `cfg_set` with `cfg_precision`=4, then `in_act`=16'h1234, `in_weight`=8'h05.
   - Required: `set` pulses once with `precision`=4.
   - Required: `valid`=1 for exactly 4 cycles, `w`=0,1,0,1, `act`=16'h1234 throughout.
2. **Back-to-back.** Precision 4; words (16'h1234, 4'b0101) then (16'hf234, 4'b1010) offered continuously.
   - Required: `valid` high for 8 consecutive cycles, `w`=0,1,0,1,1,0,1,0.
   - Required: `act` switches to 16'hf234 exactly at the 5th bit.
3. **Clamp.**
   - `cfg_precision`=0 → `precision`=2, and weight 2'b10 streams as 1,0.
   - `cfg_precision`=12 with W_MAX=8 → `precision`=8, with 8 bits streamed.
4. **Config while busy.** `cfg_set` asserted mid-word with value 6.
   - Required: `cfg_ready`=0, the request is ignored, `precision` stays 4, and the stream is unaffected.
5. **Underflow gap.** `in_valid` is dropped after one word.
   - Required: `valid`=0 the cycle after the last bit, `busy`=0, `act` held.
   - Required: a word offered 3 cycles later streams normally.
6. **Reset mid-stream.** `rst`=0 asynchronously after bit 2 of a precision-4 word.
   - Required: all outputs take their reset values immediately.
   - Required: after release, `precision`=4 and a new word streams all 4 bits correctly.
